// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit width and elaboration-time sizing functions.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // Smallest counter width that can hold the value bin_w.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  // True when DIGITS decimal digits can represent every BIN_W-bit value.
  function automatic bit digits_ok(input int bin_w, input int digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10   = 64'd1;
    max_bin = (64'd1 << bin_w) - 64'd1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 64'd10;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
// After the following left shift, such a digit produces a decimal carry into the next nibble.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= DIGIT_W'(5)) adj = digit + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential double-dabble converter with a fixed BIN_W-cycle conversion.
// Uses the start/ready/done-tick handshake; bcd_o is a dedicated hold register.
module bin2bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [BIN_W-1:0]          bin_i,
  output logic                      ready_o,
  output logic                      done_tick_o,
  output logic [DIGIT_W*DIGITS-1:0] bcd_o
);

  // state | meaning
  // IDLE  | waiting for start_i; ready_o high
  // OP    | one double-dabble step per cycle, BIN_W steps in total
  // DONE  | single-cycle done_tick_o, bcd_o freshly loaded

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int BCD_W = DIGIT_W * DIGITS;

  if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_digits
    $error("bin2bcd_converter: DIGITS too small for BIN_W");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [BIN_W-1:0]   bin_next;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_sr [d*DIGIT_W +: DIGIT_W]),
      .adj   (bcd_adj[d*DIGIT_W +: DIGIT_W])
    );
  end

  // Shift {bcd, bin} left by one after correction.
  assign bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign bin_next = {bin_sr[BIN_W-2:0], 1'b0};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
      bcd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            bin_sr <= bin_i;
            bcd_sr <= '0;
            cnt    <= CNT_W'(BIN_W);
            state  <= OP;
          end
        end
        OP: begin
          bin_sr <= bin_next;
          bcd_sr <= bcd_next;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_q <= bcd_next;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state == IDLE);
  assign done_tick_o = (state == DONE);
  assign bcd_o       = bcd_q;

endmodule
